data_mem_unit: RTL
==================

DATA_MEM_UNIT -- requirements
Module: data_mem_unit

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words (power of two, 16..65536).
REQ-002 SHALL have parameter LATENCY, default 1, cycles from request acceptance to response (1..15).
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port stall  input  1  pipeline stall: blocks acceptance, freezes wait counter, holds response.
REQ-006 SHALL have port req_valid  input  1  request present.
REQ-007 SHALL have port req_ready  output  1  unit can accept a request this cycle.
REQ-008 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-009 SHALL have port req_size  input  2  access size: 00 = byte, 01 = half, 10 = word, 11 = reserved (treated as word).
REQ-010 SHALL have port req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
REQ-011 SHALL have port req_addr  input  32  byte address; word index = req_addr[log2(DEPTH_WORDS)+1:2], upper bits ignored.
REQ-012 SHALL have port req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-013 SHALL have port resp_valid  output  1  response present.
REQ-014 SHALL have port resp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errored accesses.
REQ-015 SHALL have port addr_err  output  1  qualifies resp_valid: access was misaligned.

Function
REQ-016 SHALL accept a request on a rising edge where req_valid=1, req_ready=1 and stall=0; acceptance latches write, size, signed, addr and wdata.
REQ-017 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; IDLE goes directly to RESP when LATENCY=1; otherwise it enters WAIT with a counter loaded to LATENCY-1.
REQ-018 SHALL assert req_ready only in IDLE, so back-to-back accesses are spaced LATENCY+1 cycles apart.
REQ-019 SHALL decrement the WAIT counter only while stall=0, and leave WAIT for RESP on the edge where the counter is 1 and stall=0.
REQ-020 SHALL assert resp_valid only in RESP; RESP SHALL hold, with outputs stable, while stall=1, and return to IDLE on the first edge with stall=0.
REQ-021 SHALL commit stores on the acceptance edge, writing only the addressed byte lanes: byte -> lane addr[1:0]; half -> lanes {addr[1],0} and {addr[1],1}; word -> all four lanes (little-endian).
REQ-022 SHALL sample load data on the acceptance edge, so a load returns memory contents from before any later store.
REQ-023 SHALL select the addressed lane(s) for loads and extend them per req_signed; word loads SHALL ignore req_signed.
REQ-024 SHALL ignore req_valid while not in IDLE; no request is queued.
REQ-025 SHALL wrap addresses beyond DEPTH_WORDS modulo the depth, without error.

Reset
REQ-026 SHALL, while reset=0, force the FSM to IDLE, the counter to 0, resp_valid=0, addr_err=0 and resp_rdata=0, and drive req_ready=0.
REQ-027 SHALL abandon any in-flight access when reset is asserted mid-operation; a store already committed on its acceptance edge SHALL remain in memory.
REQ-028 SHALL NOT clear memory contents on reset; the array SHALL be uninitialised after power-up.

Configuration
REQ-029 SHALL provide macro DMEM_MISALIGN_CHECK_EN: when defined, a half access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL suppress the store, return resp_rdata=0, and raise addr_err with resp_valid.
REQ-030 SHALL, when DMEM_MISALIGN_CHECK_EN is undefined, tie addr_err to 0 and force misaligned addresses to natural alignment (clear addr[0] for half, addr[1:0] for word).

Verification
REQ-031 SHALL check: LATENCY=1, store word 0xDEADBEEF at 0x10, then load word at 0x10 -> resp_valid exactly 1 cycle after acceptance, resp_rdata=0xDEADBEEF.
REQ-032 SHALL check: after REQ-031, store byte 0x80 at 0x12, then load signed byte at 0x12 -> 0xFFFFFF80; unsigned byte -> 0x00000080; word -> 0xDE80BEEF.
REQ-033 SHALL check: LATENCY=3, load accepted, stall=1 for 2 cycles during WAIT -> resp_valid appears 5 cycles after acceptance; stall=1 during RESP holds resp_valid until stall drops.
REQ-034 SHALL check: with DMEM_MISALIGN_CHECK_EN, store word 0x12345678 at 0x22 -> addr_err=1, resp_rdata=0, and the word at 0x20 is unchanged; without the macro, the same store writes the word at 0x20.
REQ-035 SHALL check: reset=0 asserted in WAIT -> next cycle resp_valid=0 and req_ready=0; after release, req_ready=1 and no stale response appears.
REQ-036 SHALL check: DEPTH_WORDS=1024, store to 0x1004 then load from 0x0004 -> same data (wrap-around).

Source files
------------

// File: rtl/data_mem_unit.sv
// data_mem_unit: byte-addressable data memory with fixed-latency handshake.
// Word array of DEPTH_WORDS x 32, little-endian byte lanes, configurable
// response LATENCY (1..15), stall-aware, no contents reset.
//
// Ports:
//   clk          sole clock, rising edge
//   reset        asynchronous, active-low
//   stall        blocks acceptance, freezes wait counter, holds response
//   req_valid    request present
//   req_ready    unit can accept a request this cycle (IDLE only)
//   req_write    1 = store, 0 = load
//   req_size     00 byte, 01 half, 10 word, 11 treated as word
//   req_signed   loads: 1 sign-extend, 0 zero-extend
//   req_addr     byte address, word index = req_addr[log2(DEPTH_WORDS)+1:2]
//   req_wdata    store data, right-aligned
//   resp_valid   response present (RESP state)
//   resp_rdata   extended load result, 0 for stores and errored accesses
//   addr_err     misaligned access flag, qualifies resp_valid
//
// Optional feature macro: DMEM_MISALIGN_CHECK_EN
//   defined   : misaligned half/word accesses are flagged and suppressed
//   undefined : addr_err tied low, misaligned addresses naturally aligned

module data_mem_unit #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        addr_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nx;

    logic        accept;

    logic        is_byte;
    logic        is_half;
    logic        is_word;
    logic [1:0]  lane;
    logic [AW-1:0] idx;
    logic        err_now;

    logic [3:0]  be;
    logic [31:0] wd_lane;
    logic        we;

    logic [31:0] rd_word;
    logic [31:0] rd_sh;
    logic [31:0] ld_val;
    logic [31:0] resp_nx;

    logic [31:0] data_q;
    logic        err_q;

    logic        unused_addr;

    logic [31:0] mem [DEPTH_WORDS];

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    assign is_byte = (req_size == 2'b00);
    assign is_half = (req_size == 2'b01);
    assign is_word = req_size[1];

    assign idx = req_addr[AW+1:2];

    // Upper address bits beyond the array wrap silently.
    assign unused_addr = ^req_addr[31:AW+2];

    // Lane offset after natural alignment; byte keeps both low bits.
    always_comb begin
        lane = 2'b00;
        unique case (1'b1)
            is_byte: lane = req_addr[1:0];
            is_half: lane = {req_addr[1], 1'b0};
            is_word: lane = 2'b00;
            default: lane = 2'b00;
        endcase
    end

`ifdef DMEM_MISALIGN_CHECK_EN
    assign err_now = (is_half & req_addr[0])
                   | (is_word & (req_addr[1:0] != 2'b00));
`else
    assign err_now = 1'b0;
`endif

    assign accept = req_valid & req_ready & ~stall;

    // ------------------------------------------------------------------
    // Store path: shift data into its lanes, enable only those lanes
    // ------------------------------------------------------------------
    assign wd_lane = req_wdata << {lane, 3'b000};

    always_comb begin
        be = 4'b1111;
        unique case (1'b1)
            is_byte: be = 4'b0001 << lane;
            is_half: be = 4'b0011 << lane;
            is_word: be = 4'b1111;
            default: be = 4'b1111;
        endcase
    end

    assign we = accept & req_write & ~err_now;

    // Contents survive reset; only the committed lanes change.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wd_lane[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Load path: read and extend at acceptance, hold until response
    // ------------------------------------------------------------------
    assign rd_word = mem[idx];
    assign rd_sh   = rd_word >> {lane, 3'b000};

    always_comb begin
        ld_val = rd_word;
        unique case (1'b1)
            is_byte: ld_val = {{24{req_signed & rd_sh[7]}},
                               rd_sh[7:0]};
            is_half: ld_val = {{16{req_signed & rd_sh[15]}},
                               rd_sh[15:0]};
            is_word: ld_val = rd_word;
            default: ld_val = rd_word;
        endcase
    end

    assign resp_nx = (req_write | err_now) ? 32'h0 : ld_val;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q <= 32'h0;
            err_q  <= 1'b0;
        end else if (accept) begin
            data_q <= resp_nx;
            err_q  <= err_now;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_nx = RESP;
                    end else begin
                        state_nx = WAIT;
                        cnt_nx   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (!stall) begin
                    if (cnt == 4'd1) begin
                        state_nx = RESP;
                        cnt_nx   = 4'd0;
                    end else begin
                        cnt_nx = cnt - 4'd1;
                    end
                end
            end
            RESP: begin
                if (!stall) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = 4'd0;
            end
        endcase
    end

    // ready is gated by reset so nothing is accepted while held in reset
    assign req_ready  = reset & (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_rdata = resp_valid ? data_q : 32'h0;
    assign addr_err   = resp_valid & err_q;

endmodule
